// File: rtl/event_rr_arbiter.sv
// -----------------------------------------------------------------------------
// event_rr_arbiter
//
// Round-robin arbiter with a valid/ready grant handshake. It serialises N
// level-sensitive request lines onto a shared event bus. The one-hot grant and
// its encoded index are registered. A grant is held until it is accepted, and
// the next grant can follow on the same edge with no bubble.
//
// Optional feature: define ARB_TIMEOUT_EN to drop a grant that has waited
// TIMEOUT cycles for ready_i. Without the macro no counter logic exists and
// timeout_o is tied to 0.
//
// Parameters:
//   N        number of requesters (>= 2)
//   AW       address width (>= clog2(N))
//   TIMEOUT  cycles a grant may wait before being dropped (>= 1, macro only)
//
// Ports:
//   clk_i      clock
//   reset_i    asynchronous, active-high reset
//   enable_i   permits new grants; an outstanding handshake still completes
//   req_i      request lines, level-sensitive
//   ready_i    downstream accepts the current grant
//   valid_o    grant outstanding
//   gnt_o      one-hot grant, zero when valid_o = 0
//   addr_o     index of the granted requester, zero when valid_o = 0
//   timeout_o  one-cycle pulse when a grant is dropped by timeout
// -----------------------------------------------------------------------------
module event_rr_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic [N-1:0]  req_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [N-1:0]  gnt_o,
    output logic [AW-1:0] addr_o,
    output logic          timeout_o
);

    // Elaboration-time parameter checks.
    if (N < 2) begin : g_bad_n
        $error("event_rr_arbiter: N must be at least 2");
    end
    if ((1 << AW) < N) begin : g_bad_aw
        $error("event_rr_arbiter: AW too small for N");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("event_rr_arbiter: TIMEOUT must be at least 1");
    end

    logic          r_valid;
    logic [N-1:0]  r_gnt;
    logic [AW-1:0] r_addr;
    logic [N-1:0]  r_mask;

    logic          w_hs;
    logic          w_to;
    logic          w_serve;
    logic          w_load;
    logic [N-1:0]  w_req_eff;
    logic [N-1:0]  w_mask_req;
    logic [N-1:0]  w_pick_src;
    logic [N-1:0]  w_gnt_next;
    logic [N-1:0]  w_mask_next;
    logic [AW-1:0] w_addr_next;
    logic          w_found;

    assign w_hs    = r_valid & ready_i;
    // A timed-out grant is retired exactly like an accepted one.
    assign w_serve = w_hs | w_to;

    // The requester retired this cycle must not win this cycle's arbitration.
    assign w_req_eff  = req_i & ~(w_serve ? r_gnt : '0);
    assign w_mask_req = w_req_eff & r_mask;
    assign w_pick_src = (|w_mask_req) ? w_mask_req : w_req_eff;

    assign w_load = enable_i & (|w_req_eff) & (~r_valid | w_serve);

    // Lowest-set-bit pick. The next mask has every bit above the winner set;
    // that is zero for the top index, which forces the raw path next time.
    always_comb begin
        w_gnt_next  = '0;
        w_addr_next = '0;
        w_mask_next = '0;
        w_found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_mask_next[j] = w_found;
            if (w_pick_src[j] && !w_found) begin
                w_found        = 1'b1;
                w_gnt_next[j]  = 1'b1;
                w_addr_next    = AW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_mask  <= '1;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_gnt   <= w_gnt_next;
            r_addr  <= w_addr_next;
            r_mask  <= w_mask_next;
        end else if (w_serve) begin
            r_valid <= 1'b0;
            r_gnt   <= '0;
            r_addr  <= '0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // A handshake takes precedence, so no timeout when ready_i is high.
    assign w_to = r_valid & ~ready_i & (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to;
            if (w_load || w_serve || !r_valid) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_to      = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign valid_o = r_valid;
    assign gnt_o   = r_gnt;
    assign addr_o  = r_addr;

endmodule

// File: tb/tb_event_rr_arbiter.sv
// Self-checking bench for event_rr_arbiter (N=4). The reference model tracks
// the last served index and picks the next requester by a circular scan.
module tb_event_rr_arbiter;

    localparam int N       = 4;
    localparam int AW      = 2;
    localparam int TIMEOUT = 4;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          enable_i = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [N-1:0]  gnt_o;
    logic [AW-1:0] addr_o;
    logic          timeout_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_last;
    int m_wait;
    bit m_to;

    event_rr_arbiter #(
        .N       (N),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .req_i     (req_i),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .gnt_o     (gnt_o),
        .addr_o    (addr_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] exp_vec();
        logic [N-1:0]  g;
        logic [AW-1:0] a;
        g = '0;
        a = '0;
        if (m_valid) begin
            g[m_idx] = 1'b1;
            a = AW'(m_idx);
        end
        return {m_valid, g, a, m_to};
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_last  = N - 1;
        m_wait  = 0;
        m_to    = 0;
    endtask

    // Advance the model by one clock given the inputs of that cycle.
    task automatic model_step(input logic [N-1:0] req, input bit rdy, input bit en);
        bit           to;
        bit           serve;
        logic [N-1:0] eff;
        int           pick;
        to = 0;
`ifdef ARB_TIMEOUT_EN
        to = m_valid && !rdy && (m_wait == TIMEOUT - 1);
`endif
        serve = m_valid && (rdy || to);
        eff = req;
        if (serve) eff[m_idx] = 1'b0;
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (pick < 0 && eff[j]) pick = j;
        end
        if (en && pick >= 0 && (!m_valid || serve)) begin
            m_valid = 1;
            m_idx   = pick;
            m_last  = pick;
            m_wait  = 0;
        end else if (serve) begin
            m_valid = 0;
            m_wait  = 0;
        end else if (m_valid) begin
            m_wait++;
        end
        m_to = to;
    endtask

    // Drive one cycle of inputs, step the model, sample #1 after the edge.
    task automatic tick(input logic [N-1:0] req, input bit rdy, input bit en);
        req_i    = req;
        ready_i  = rdy;
        enable_i = en;
        model_step(req, rdy, en);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_i = 1'b1; req_i = 4'b1111; ready_i = 1'b1; enable_i = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if ({valid_o, gnt_o, addr_o, timeout_o} !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold: got %b want %b", {valid_o, gnt_o, addr_o, timeout_o}, 8'h00);
            end
        end
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(4'b1111, 1, 1);
            checks++;
            if ({valid_o, gnt_o, addr_o} !== {1'b1, seq[i], AW'(i % N)} ||
                {valid_o, gnt_o, addr_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_rr_seq[%0d]: got v=%b g=%b a=%0d want g=%b a=%0d",
                         i, valid_o, gnt_o, addr_o, seq[i], i % N);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] g;
            g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            tick(4'b1010, 1, 1);
            checks++;
            if ({valid_o, gnt_o, addr_o, timeout_o} !== {1'b1, g, AW'((i % 2 == 0) ? 1 : 3), 1'b0}) begin
                errors++;
                $display("FAIL alternate[%0d]: got g=%b a=%0d want g=%b", i, gnt_o, addr_o, g);
            end
        end
    endtask

    task automatic test_sticky();
        do_reset();
        tick(4'b0001, 0, 1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({valid_o, gnt_o, addr_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL sticky[%0d]: got %b want %b", i, {valid_o, gnt_o, addr_o, timeout_o}, exp_vec());
            end
`ifndef ARB_TIMEOUT_EN
            checks++;
            if ({valid_o, gnt_o} !== 5'b1_0001) begin
                errors++;
                $display("FAIL sticky_hold[%0d]: got v=%b g=%b want v=1 g=0001", i, valid_o, gnt_o);
            end
`endif
            tick(4'b0000, (i == 4), 1);
        end
        checks++;
        if (valid_o !== 1'b0 || valid_o !== m_valid) begin
            errors++;
            $display("FAIL sticky_release: got valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bit v;
            v = (i % 2 == 0);
            tick(4'b0100, 1, 1);
            checks++;
            if (valid_o !== v || addr_o !== (v ? AW'(2) : AW'(0)) || gnt_o !== (v ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single[%0d]: got v=%b a=%0d want v=%b", i, valid_o, addr_o, v);
            end
        end
    endtask

    task automatic test_enable();
        logic [4:0] want [4];
        bit         rdy  [4];
        bit         en   [4];
        want = '{5'b1_0001, 5'b0_0000, 5'b0_0000, 5'b1_0010};
        rdy  = '{0, 1, 1, 1};
        en   = '{1, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(4'b0011, rdy[i], en[i]);
            checks++;
            if ({valid_o, gnt_o} !== want[i] || {valid_o, gnt_o, addr_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL enable[%0d]: got %b want %b", i, {valid_o, gnt_o}, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(4'b1100, 0, 1);
        tick(4'b1100, 0, 1);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({valid_o, gnt_o, addr_o, timeout_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got %b want 0", {valid_o, gnt_o, addr_o, timeout_o});
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        tick(4'b1111, 1, 1);
        checks++;
        if ({valid_o, gnt_o, addr_o} !== 7'b1_0001_00) begin
            errors++;
            $display("FAIL reset_mid_first: got g=%b a=%0d want g=0001 a=0", gnt_o, addr_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            logic [5:0] want;
            tick(4'b0011, 0, 1);
            want = (i < 4) ? 6'b1_0001_0 : (i == 4) ? 6'b1_0010_1 : 6'b1_0010_0;
            checks++;
            if ({valid_o, gnt_o, timeout_o} !== want || {valid_o, gnt_o, addr_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b want %b", i, {valid_o, gnt_o, timeout_o}, want);
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick(4'b0011, 0, 1);
            checks++;
            if ({valid_o, gnt_o, timeout_o} !== 6'b1_0001_0) begin
                errors++;
                $display("FAIL no_timeout[%0d]: got %b want 100010", i, {valid_o, gnt_o, timeout_o});
            end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            tick(r, $urandom_range(0, 3) != 0 && i % 50 > 8, $urandom_range(0, 7) != 0);
            checks++;
            if ({valid_o, gnt_o, addr_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", i, {valid_o, gnt_o, addr_o, timeout_o}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_sticky();
        test_single();
        test_enable();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
